// File: rtl/marie_core.sv
// rtl/marie_core.sv - multicycle MARIE accumulator CPU with synchronous one-cycle-latency memory port
module marie_core #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  halted,
  output logic                  instr_done,
  output logic [ADDR_WIDTH-1:0] pc_dbg,
  output logic [DATA_WIDTH-1:0] ac_dbg
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_FETCH_W  = 4'd2;
  localparam logic [3:0] ST_DECODE   = 4'd3;
  localparam logic [3:0] ST_IND_RD   = 4'd4;
  localparam logic [3:0] ST_IND_W    = 4'd5;
  localparam logic [3:0] ST_OP_RD    = 4'd6;
  localparam logic [3:0] ST_OP_W     = 4'd7;
  localparam logic [3:0] ST_EXEC     = 4'd8;
  localparam logic [3:0] ST_STORE_WR = 4'd9;
  localparam logic [3:0] ST_HALTED   = 4'd10;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_LOAD     = 4'h1;
  localparam logic [3:0] OP_STORE    = 4'h2;
  localparam logic [3:0] OP_ADD      = 4'h3;
  localparam logic [3:0] OP_SUB      = 4'h4;
  localparam logic [3:0] OP_AND      = 4'h5;
  localparam logic [3:0] OP_OR       = 4'h6;
  localparam logic [3:0] OP_NOT      = 4'h7;
  localparam logic [3:0] OP_STOREI   = 4'h8;
  localparam logic [3:0] OP_SKIPCOND = 4'h9;
  localparam logic [3:0] OP_JUMP     = 4'hA;
  localparam logic [3:0] OP_CLEAR    = 4'hB;
  localparam logic [3:0] OP_MUL      = 4'hC;
  localparam logic [3:0] OP_LOADI    = 4'hD;
  localparam logic [3:0] OP_JUMPI    = 4'hE;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ac_q, ac_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
  logic [ADDR_WIDTH-1:0] ea_q, ea_d;

  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand_x;
  logic [1:0]            skip_cond;
  logic                  skip_taken;
  logic [DATA_WIDTH-1:0] alu_result;

  assign opcode    = ir_q[DATA_WIDTH-1 -: 4];
  assign operand_x = ir_q[ADDR_WIDTH-1:0];
  assign skip_cond = operand_x[ADDR_WIDTH-1 -: 2];

  assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign halted = (state_q == ST_HALTED);
  assign pc_dbg = pc_q;
  assign ac_dbg = ac_q;

  // SKIPCOND treats AC as two's complement; condition 11 never skips
  always_comb begin
    skip_taken = 1'b0;
    case (skip_cond)
      2'b00:   skip_taken = ac_q[DATA_WIDTH-1];
      2'b01:   skip_taken = (ac_q == '0);
      2'b10:   skip_taken = !ac_q[DATA_WIDTH-1] && (ac_q != '0);
      default: skip_taken = 1'b0;
    endcase
  end

  // memory-operand ALU used in EXEC; arithmetic wraps, MUL keeps the low word
  always_comb begin
    alu_result = ac_q;
    case (opcode)
      OP_LOAD, OP_LOADI: alu_result = mbr_q;
      OP_ADD:            alu_result = ac_q + mbr_q;
      OP_SUB:            alu_result = ac_q - mbr_q;
      OP_AND:            alu_result = ac_q & mbr_q;
      OP_OR:             alu_result = ac_q | mbr_q;
      OP_MUL:            alu_result = ac_q * mbr_q;
      default:           alu_result = ac_q;
    endcase
  end

  // memory port is a pure function of state so reset drops mem_we immediately
  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_FETCH: begin
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        mem_addr = pc_q;
      end
      ST_IND_RD, ST_OP_RD: begin
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        mem_addr = ea_q;
      end
      ST_STORE_WR: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ea_q;
        mem_wdata = ac_q;
      end
      default: ;
    endcase
  end

  // fetch/decode/execute sequencing and architectural register updates
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ac_d       = ac_q;
    ir_d       = ir_q;
    mbr_d      = mbr_q;
    ea_d       = ea_q;
    instr_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_FETCH_W;
      ST_FETCH_W: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + PC_ONE;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ea_d = operand_x;
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL: state_d = ST_OP_RD;
          OP_STORE:                      state_d = ST_STORE_WR;
          OP_STOREI, OP_LOADI, OP_JUMPI: state_d = ST_IND_RD;
          OP_NOT: begin
            ac_d       = ~ac_q;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          OP_SKIPCOND: begin
            if (skip_taken) pc_d = pc_q + PC_ONE;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          OP_JUMP: begin
            pc_d       = operand_x;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          OP_CLEAR: begin
            ac_d       = '0;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          OP_HALT: begin
            instr_done = 1'b1;
            state_d    = ST_HALTED;
          end
          default: begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
        endcase
      end
      ST_IND_RD: state_d = ST_IND_W;
      ST_IND_W: begin
        ea_d = mem_rdata[ADDR_WIDTH-1:0];
        if (opcode == OP_JUMPI) begin
          pc_d       = mem_rdata[ADDR_WIDTH-1:0];
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (opcode == OP_STOREI) begin
          state_d = ST_STORE_WR;
        end else begin
          state_d = ST_OP_RD;
        end
      end
      ST_OP_RD: state_d = ST_OP_W;
      ST_OP_W: begin
        mbr_d   = mem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        ac_d       = alu_result;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_STORE_WR: begin
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // state and register flops; reset abandons whatever is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ac_q    <= '0;
      ir_q    <= '0;
      mbr_q   <= '0;
      ea_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      ir_q    <= ir_d;
      mbr_q   <= mbr_d;
      ea_q    <= ea_d;
    end
  end

endmodule

// File: tb/tb_marie_core.sv
// tb/tb_marie_core.sv - scoreboard bench for marie_core against an ISA reference model
module tb_marie_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_cs, mem_we, mem_oe;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy, halted, instr_done;
  logic [11:0] pc_dbg;
  logic [15:0] ac_dbg;

  always #5 clk = ~clk;

  marie_core #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .RESET_PC(12'h100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .halted(halted), .instr_done(instr_done),
    .pc_dbg(pc_dbg), .ac_dbg(ac_dbg)
  );

  // synchronous RAM with one-cycle read latency plus a preload port
  logic [15:0] mem [0:4095];
  logic        ld_en = 1'b0, ld_clr = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [15:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
    end else if (ld_en) begin
      mem[ld_addr] = ld_data;
    end else if (mem_cs && mem_we) begin
      mem[mem_addr] = mem_wdata;
    end
    if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [11:0] pc;
    logic [15:0] ac;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mm [0:4095];
  logic [11:0] m_pc;
  logic [15:0] m_ac;
  int          total = 0;
  int          bad = 0;
  int          cyc_cnt = 0;
  int          we_cnt = 0;
  bit          chk_pend = 0;
  logic [11:0] pend_pc;
  logic [15:0] pend_ac;

  // ISA reference: executes up to max_instr instructions, pushing post-state and cycle cost
  task automatic model_run(input int max_instr);
    logic [15:0] ir, v;
    logic [11:0] x;
    int          cyc;
    bit          stop, skip;
    stop = 0;
    for (int n = 0; n < max_instr && !stop; n++) begin
      ir   = mm[m_pc];
      m_pc = m_pc + 12'd1;
      x    = ir[11:0];
      cyc  = 3;
      case (ir[15:12])
        4'h1: begin m_ac = mm[x]; cyc = 6; end
        4'h2: begin mm[x] = m_ac; cyc = 4; end
        4'h3: begin m_ac = m_ac + mm[x]; cyc = 6; end
        4'h4: begin m_ac = m_ac - mm[x]; cyc = 6; end
        4'h5: begin m_ac = m_ac & mm[x]; cyc = 6; end
        4'h6: begin m_ac = m_ac | mm[x]; cyc = 6; end
        4'h7: m_ac = ~m_ac;
        4'h8: begin v = mm[x]; mm[v[11:0]] = m_ac; cyc = 6; end
        4'h9: begin
          case (x[11:10])
            2'b00:   skip = ($signed(m_ac) < 0);
            2'b01:   skip = (m_ac == 16'h0000);
            2'b10:   skip = ($signed(m_ac) > 0);
            default: skip = 0;
          endcase
          if (skip) m_pc = m_pc + 12'd1;
        end
        4'hA: m_pc = x;
        4'hB: m_ac = 16'h0000;
        4'hC: begin m_ac = m_ac * mm[x]; cyc = 6; end
        4'hD: begin v = mm[x]; m_ac = mm[v[11:0]]; cyc = 8; end
        4'hE: begin v = mm[x]; m_pc = v[11:0]; cyc = 5; end
        4'hF: stop = 1;
        default: ;
      endcase
      exp_q.push_back('{pc: m_pc, ac: m_ac, cyc: cyc});
    end
  endtask

  // advance one cycle, sample at negedge, retire scoreboard entries on instr_done
  task automatic step_cycle();
    exp_t e;
    @(negedge clk);
    cyc_cnt++;
    if (mem_cs && mem_we) we_cnt++;
    total++;
    if (mem_we && mem_oe) begin
      bad++;
      $display("FAIL we_oe_exclusive: we=%b oe=%b want not both", mem_we, mem_oe);
    end
    if (chk_pend) begin
      chk_pend = 0;
      total++;
      if (pc_dbg !== pend_pc) begin
        bad++;
        $display("FAIL sb_pc: got %h want %h", pc_dbg, pend_pc);
      end
      total++;
      if (ac_dbg !== pend_ac) begin
        bad++;
        $display("FAIL sb_ac: got %h want %h", ac_dbg, pend_ac);
      end
    end
    if (instr_done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: got done at pc %h want none", pc_dbg);
      end else begin
        e = exp_q.pop_front();
        if (cyc_cnt !== e.cyc) begin
          bad++;
          $display("FAIL sb_cycles: got %0d want %0d", cyc_cnt, e.cyc);
        end
        pend_pc  = e.pc;
        pend_ac  = e.ac;
        chk_pend = 1;
      end
      cyc_cnt = 0;
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    mm[a]   = d;
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    exp_q.delete();
    chk_pend = 0;
    we_cnt   = 0;
    ld_clr   = 1'b1;
    @(negedge clk);
    ld_clr = 1'b0;
    for (int i = 0; i < 4096; i++) mm[i] = '0;
    m_pc = 12'h100;
    m_ac = 16'h0000;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start   = 1'b1;
    cyc_cnt = 0;
    step_cycle();
    start = 1'b0;
  endtask

  task automatic run_until_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) step_cycle();
    total++;
    if (halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_timeout: got halted=%b want 1", halted);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({busy, halted, instr_done, mem_cs, mem_we, mem_oe} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000", {busy, halted, instr_done, mem_cs, mem_we, mem_oe});
    end
    total++;
    if (mem_addr !== 12'h000 || mem_wdata !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mem_bus: got %h/%h want 000/0000", mem_addr, mem_wdata);
    end
    total++;
    if (pc_dbg !== 12'h100) begin
      bad++;
      $display("FAIL reset_pc: got %h want 100", pc_dbg);
    end
    total++;
    if (ac_dbg !== 16'h0000) begin
      bad++;
      $display("FAIL reset_ac: got %h want 0000", ac_dbg);
    end
    release_reset();
    total++;
    if (busy !== 1'b0 || pc_dbg !== 12'h100) begin
      bad++;
      $display("FAIL idle_without_start: got busy=%b pc=%h want 0/100", busy, pc_dbg);
    end
  endtask

  task automatic test_multiply();
    do_reset();
    poke(12'h100, 16'h110C); poke(12'h101, 16'h9400); poke(12'h102, 16'hA104);
    poke(12'h103, 16'hF000); poke(12'h104, 16'h110D); poke(12'h105, 16'h310B);
    poke(12'h106, 16'h210D); poke(12'h107, 16'h110C); poke(12'h108, 16'h310F);
    poke(12'h109, 16'h210C); poke(12'h10A, 16'hA100); poke(12'h10B, 16'h0005);
    poke(12'h10C, 16'h0007); poke(12'h10F, 16'hFFFF);
    model_run(200);
    release_reset();
    pulse_start();
    run_until_halt(3000);
    total++;
    if (mem[12'h10D] !== 16'h0023) begin
      bad++;
      $display("FAIL mult_result: got %h want 0023", mem[12'h10D]);
    end
    total++;
    if (pc_dbg !== 12'h104 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mult_final: got pc=%h busy=%b want 104/0", pc_dbg, busy);
    end
  endtask

  task automatic test_mul();
    do_reset();
    poke(12'h100, 16'h1200); poke(12'h101, 16'hC201); poke(12'h102, 16'hF000);
    poke(12'h200, 16'h0300); poke(12'h201, 16'h0101);
    model_run(10);
    release_reset();
    pulse_start();
    run_until_halt(200);
    total++;
    if (ac_dbg !== 16'h0300) begin
      bad++;
      $display("FAIL mul_low_word: got %h want 0300", ac_dbg);
    end
  endtask

  task automatic test_skipcond();
    do_reset();
    poke(12'h100, 16'h1200); poke(12'h101, 16'h9000); poke(12'h102, 16'hF000);
    poke(12'h103, 16'h9800); poke(12'h104, 16'hB000); poke(12'h105, 16'h9400);
    poke(12'h106, 16'hF000); poke(12'h107, 16'h7000); poke(12'h108, 16'h9C00);
    poke(12'h109, 16'hF000); poke(12'h200, 16'h8000);
    model_run(20);
    release_reset();
    pulse_start();
    run_until_halt(300);
    total++;
    if (pc_dbg !== 12'h10A || ac_dbg !== 16'hFFFF) begin
      bad++;
      $display("FAIL skip_path: got pc=%h ac=%h want 10A/FFFF", pc_dbg, ac_dbg);
    end
  endtask

  task automatic test_indirect();
    do_reset();
    poke(12'h100, 16'hD300); poke(12'h101, 16'h1210); poke(12'h102, 16'h8300);
    poke(12'h103, 16'hE211); poke(12'h120, 16'hF000); poke(12'h300, 16'h0310);
    poke(12'h310, 16'hBEEF); poke(12'h210, 16'h1234); poke(12'h211, 16'h0120);
    model_run(20);
    release_reset();
    we_cnt = 0;
    pulse_start();
    run_until_halt(300);
    total++;
    if (mem[12'h310] !== 16'h1234) begin
      bad++;
      $display("FAIL storei_data: got %h want 1234", mem[12'h310]);
    end
    total++;
    if (we_cnt !== 1) begin
      bad++;
      $display("FAIL storei_we_pulses: got %0d want 1", we_cnt);
    end
    total++;
    if (pc_dbg !== 12'h121) begin
      bad++;
      $display("FAIL jumpi_target: got %h want 121", pc_dbg);
    end
  endtask

  task automatic test_reset_during_store();
    do_reset();
    poke(12'h100, 16'h1200); poke(12'h101, 16'h2250);
    poke(12'h200, 16'hAAAA); poke(12'h250, 16'h5555);
    model_run(2);
    release_reset();
    pulse_start();
    for (int i = 0; i < 40 && !mem_we; i++) step_cycle();
    total++;
    if (mem_we !== 1'b1) begin
      bad++;
      $display("FAIL store_wr_reached: got we=%b want 1", mem_we);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk_pend = 0;
    total++;
    if ({mem_cs, mem_we, mem_oe} !== 3'b000) begin
      bad++;
      $display("FAIL reset_drops_we: got cs/we/oe=%b want 000", {mem_cs, mem_we, mem_oe});
    end
    total++;
    if (pc_dbg !== 12'h100 || busy !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got pc=%h busy=%b halted=%b want 100/0/0", pc_dbg, busy, halted);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem[12'h250] !== 16'h5555) begin
      bad++;
      $display("FAIL store_abandoned: got %h want 5555", mem[12'h250]);
    end
  endtask

  task automatic test_wrap_and_halt();
    bit          seen_zero;
    logic [11:0] pc_hold;
    logic [15:0] ac_hold;
    do_reset();
    poke(12'h100, 16'h9400); poke(12'h101, 16'hF000); poke(12'h102, 16'h7000);
    poke(12'h103, 16'hAFFF); poke(12'hFFF, 16'hA100);
    model_run(20);
    release_reset();
    pulse_start();
    seen_zero = 0;
    for (int i = 0; i < 300 && !halted; i++) begin
      step_cycle();
      if (pc_dbg === 12'h000) seen_zero = 1;
    end
    total++;
    if (seen_zero !== 1'b1) begin
      bad++;
      $display("FAIL pc_wrap: got seen=%b want 1", seen_zero);
    end
    run_until_halt(10);
    pc_hold = pc_dbg;
    ac_hold = ac_dbg;
    pulse_start();
    for (int i = 0; i < 5; i++) step_cycle();
    total++;
    if (halted !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL start_while_halted: got halted=%b busy=%b want 1/0", halted, busy);
    end
    total++;
    if (pc_dbg !== pc_hold || ac_dbg !== ac_hold || pc_hold !== 12'h102) begin
      bad++;
      $display("FAIL halted_state_frozen: got pc=%h ac=%h want 102/%h", pc_dbg, ac_dbg, ac_hold);
    end
    total++;
    if ({mem_cs, mem_we, mem_oe} !== 3'b000) begin
      bad++;
      $display("FAIL halted_mem_idle: got %b want 000", {mem_cs, mem_we, mem_oe});
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_mul();
    test_skipcond();
    test_indirect();
    test_reset_during_store();
    test_wrap_and_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
